// File: rtl/hdmi_out_timing_pkg.sv
// Shared defaults and types for the HDMI output timing generator.
// Timing defaults are CEA-861 1280x720p60.
package hdmi_out_timing_pkg;

  localparam int RGB_W = 24;
  localparam int CNT_W = 12;

  localparam logic [CNT_W-1:0] DEF_H_ACT  = 12'd1280;
  localparam logic [CNT_W-1:0] DEF_H_FP   = 12'd110;
  localparam logic [CNT_W-1:0] DEF_H_SYNC = 12'd40;
  localparam logic [CNT_W-1:0] DEF_H_BP   = 12'd220;
  localparam logic [CNT_W-1:0] DEF_V_ACT  = 12'd720;
  localparam logic [CNT_W-1:0] DEF_V_FP   = 12'd5;
  localparam logic [CNT_W-1:0] DEF_V_SYNC = 12'd5;
  localparam logic [CNT_W-1:0] DEF_V_BP   = 12'd20;

  localparam logic [CNT_W-1:0] DEF_IMG_X0 = 12'd0;
  localparam logic [CNT_W-1:0] DEF_IMG_Y0 = 12'd0;
  localparam logic [CNT_W-1:0] DEF_IMG_W  = 12'd640;
  localparam logic [CNT_W-1:0] DEF_IMG_H  = 12'd720;

  localparam logic [RGB_W-1:0] DEF_BORDER = 24'h000000;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic win;
    logic fs;
  } tflags_t;

  // lo <= x < lo+len without overflowing the counter width
  function automatic logic in_range(cnt_t x, cnt_t lo, cnt_t len);
    return (x >= lo) && ((x - lo) < len);
  endfunction

endpackage

// File: rtl/hdmi_timing_cnt.sv
// Horizontal/vertical raster counters with registered stage-0 slot flags.
// Holds at h=v=0 while idle; the first running cycle is pixel (0,0).
module hdmi_timing_cnt
  import hdmi_out_timing_pkg::*;
#(
  parameter cnt_t H_ACT  = DEF_H_ACT,
  parameter cnt_t H_FP   = DEF_H_FP,
  parameter cnt_t H_SYNC = DEF_H_SYNC,
  parameter cnt_t H_BP   = DEF_H_BP,
  parameter cnt_t V_ACT  = DEF_V_ACT,
  parameter cnt_t V_FP   = DEF_V_FP,
  parameter cnt_t V_SYNC = DEF_V_SYNC,
  parameter cnt_t V_BP   = DEF_V_BP,
  parameter cnt_t IMG_X0 = DEF_IMG_X0,
  parameter cnt_t IMG_Y0 = DEF_IMG_Y0,
  parameter cnt_t IMG_W  = DEF_IMG_W,
  parameter cnt_t IMG_H  = DEF_IMG_H
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    run_i,
  output tflags_t flags_o,
  output logic    win_nxt_o
);

  localparam cnt_t H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam cnt_t V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam cnt_t HS_B  = H_ACT + H_FP;
  localparam cnt_t VS_B  = V_ACT + V_FP;

  cnt_t    h_q, h_d;
  cnt_t    v_q, v_d;
  logic    run_q;
  tflags_t fl_q, fl_d;

  function automatic tflags_t slot_flags(cnt_t h, cnt_t v);
    tflags_t f;
    f.active = (h < H_ACT) && (v < V_ACT);
    f.hs     = in_range(h, HS_B, H_SYNC);
    f.vs     = in_range(v, VS_B, V_SYNC);
    f.win    = f.active
            && in_range(h, IMG_X0, IMG_W)
            && in_range(v, IMG_Y0, IMG_H);
    f.fs     = (h == '0) && (v == '0);
    return f;
  endfunction

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!run_i || !run_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_TOT - 12'd1) begin
      h_d = '0;
      v_d = (v_q == V_TOT - 12'd1) ? '0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
    end
    fl_d = run_i ? slot_flags(h_d, v_d) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q   <= '0;
      v_q   <= '0;
      run_q <= 1'b0;
      fl_q  <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      run_q <= run_i;
      fl_q  <= fl_d;
    end
  end

  assign flags_o   = fl_q;
  assign win_nxt_o = fl_d.win;

endmodule

// File: rtl/hdmi_out_timing.sv
// HDMI output timing: raster generation, FIFO read gating, 2-stage
// output pipeline aligning sync/DE/data, and a sticky underflow flag.
module hdmi_out_timing
  import hdmi_out_timing_pkg::*;
#(
  parameter cnt_t H_ACT  = DEF_H_ACT,
  parameter cnt_t H_FP   = DEF_H_FP,
  parameter cnt_t H_SYNC = DEF_H_SYNC,
  parameter cnt_t H_BP   = DEF_H_BP,
  parameter cnt_t V_ACT  = DEF_V_ACT,
  parameter cnt_t V_FP   = DEF_V_FP,
  parameter cnt_t V_SYNC = DEF_V_SYNC,
  parameter cnt_t V_BP   = DEF_V_BP,
  parameter logic HS_POL = 1'b1,
  parameter logic VS_POL = 1'b1,
  parameter cnt_t IMG_X0 = DEF_IMG_X0,
  parameter cnt_t IMG_Y0 = DEF_IMG_Y0,
  parameter cnt_t IMG_W  = DEF_IMG_W,
  parameter cnt_t IMG_H  = DEF_IMG_H,
  parameter rgb_t BORDER = DEF_BORDER
) (
  input  logic             pixclk_in,
  input  logic             rst,
  input  logic             init_over_tx,
  input  logic             pixel_empty,
  input  logic [RGB_W-1:0] pixel_data,
  input  logic             underflow_clr,
  output logic             pixel_req,
  output logic             vs_out,
  output logic             hs_out,
  output logic             de_out,
  output logic [RGB_W-1:0] data_out,
  output logic             frame_start,
  output logic             underflow
);

  tflags_t f0;
  logic    win_nxt;

  hdmi_timing_cnt #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP),
    .IMG_X0(IMG_X0),
    .IMG_Y0(IMG_Y0),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk_i    (pixclk_in),
    .rst_i    (rst),
    .run_i    (init_over_tx),
    .flags_o  (f0),
    .win_nxt_o(win_nxt)
  );

  logic req_q;
  logic act1_q, hs1_q, vs1_q, fs1_q, hit1_q;
  logic de_q, hs_q, vs_q, fs_q, uf_q;
  rgb_t data_q;
  logic miss;

  // req_q shares the edge with f0, so both describe the same slot
  assign miss = f0.win & ~req_q;

  always_ff @(posedge pixclk_in) begin
    if (rst || !init_over_tx) begin
      req_q  <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      hit1_q <= 1'b0;
      de_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      fs_q   <= 1'b0;
      data_q <= '0;
    end else begin
      req_q  <= win_nxt & ~pixel_empty;
      act1_q <= f0.active;
      hs1_q  <= f0.hs;
      vs1_q  <= f0.vs;
      fs1_q  <= f0.fs;
      hit1_q <= req_q;
      de_q   <= act1_q;
      hs_q   <= hs1_q ? HS_POL : ~HS_POL;
      vs_q   <= vs1_q ? VS_POL : ~VS_POL;
      fs_q   <= fs1_q;
      if (!act1_q)
        data_q <= '0;
      else if (hit1_q)
        data_q <= pixel_data;
      else
        data_q <= BORDER;
    end
  end

  always_ff @(posedge pixclk_in) begin
    if (rst)
      uf_q <= 1'b0;
    else if (miss)
      uf_q <= 1'b1;
    else if (underflow_clr)
      uf_q <= 1'b0;
  end

  assign pixel_req   = req_q;
  assign de_out      = de_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign frame_start = fs_q;
  assign data_out    = data_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_hdmi_out_timing.sv
// Scoreboard bench for hdmi_out_timing on a 14x7 raster with a 4x2 window.
// The reference model walks a linear slot index per frame.
module tb_hdmi_out_timing;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FR = HT * VT;
  localparam int X0 = 2, W = 4, Y0 = 1, H = 2;
  localparam int NCYC = 2600;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam logic [23:0] BRD = 24'hA5C3E7;

  logic        pixclk_in = 1'b0;
  logic        rst, init_over_tx, pixel_empty, underflow_clr;
  logic [23:0] pixel_data;
  logic        pixel_req, vs_out, hs_out, de_out, frame_start, underflow;
  logic [23:0] data_out;

  always #5 pixclk_in = ~pixclk_in;

  hdmi_out_timing #(
    .H_ACT (12'd8), .H_FP (12'd2), .H_SYNC(12'd2), .H_BP(12'd2),
    .V_ACT (12'd4), .V_FP (12'd1), .V_SYNC(12'd1), .V_BP(12'd1),
    .HS_POL(HSP),   .VS_POL(VSP),
    .IMG_X0(12'd2), .IMG_Y0(12'd1), .IMG_W(12'd4), .IMG_H(12'd2),
    .BORDER(BRD)
  ) dut (
    .pixclk_in    (pixclk_in),
    .rst          (rst),
    .init_over_tx (init_over_tx),
    .pixel_empty  (pixel_empty),
    .pixel_data   (pixel_data),
    .underflow_clr(underflow_clr),
    .pixel_req    (pixel_req),
    .vs_out       (vs_out),
    .hs_out       (hs_out),
    .de_out       (de_out),
    .data_out     (data_out),
    .frame_start  (frame_start),
    .underflow    (underflow)
  );

  typedef struct {
    int          e;
    bit          req, de, hs, vs, fs, uf;
    logic [23:0] data;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit          srun [NCYC];
  int          st   [NCYC];
  bit          shit [NCYC];
  bit          fl   [NCYC];
  logic [23:0] sword[NCYC];

  function automatic bit f_active(int t);
    return (t % HT) < HA && (t / HT) < VA;
  endfunction
  function automatic bit f_hs(int t);
    return (t % HT) >= HA + HF && (t % HT) < HA + HF + HSW;
  endfunction
  function automatic bit f_vs(int t);
    return (t / HT) >= VA + VF && (t / HT) < VA + VF + VSW;
  endfunction
  function automatic bit f_win(int t);
    int h = t % HT;
    int v = t / HT;
    return f_active(t) && h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H;
  endfunction

  task automatic chk(string nm, int e, logic [23:0] got, logic [23:0] req);
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s edge=%0d got=%h required=%h", nm, e, got, req);
    end
  endtask

  // monitor: pops one expected record per clock edge
  initial begin
    exp_t x;
    forever begin
      @(posedge pixclk_in);
      #1;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        vectors++;
        chk("pixel_req",   x.e, 24'(pixel_req),   24'(x.req));
        chk("de_out",      x.e, 24'(de_out),      24'(x.de));
        chk("hs_out",      x.e, 24'(hs_out),      24'(x.hs));
        chk("vs_out",      x.e, 24'(vs_out),      24'(x.vs));
        chk("frame_start", x.e, 24'(frame_start), 24'(x.fs));
        chk("underflow",   x.e, 24'(underflow),   24'(x.uf));
        chk("data_out",    x.e, data_out,         x.data);
      end
    end
  end

  initial begin
    bit   run = 0, nrun, prev_req = 0, uf = 0, rst_done = 0;
    int   t = 0, nt, s, pt;
    int   word_drv = 1, word_mdl = 1;
    exp_t x;

    rst = 1'b1;
    init_over_tx = 1'b1;
    pixel_empty = 1'b0;
    underflow_clr = 1'b0;
    pixel_data = '0;

    for (int e = 0; e < NCYC; e++) begin
      @(negedge pixclk_in);
      // FIFO: word appears the cycle after the request
      if (prev_req) begin
        pixel_data = 24'(word_drv);
        word_drv++;
      end else begin
        pixel_data = 24'($urandom);
      end
      prev_req = (pixel_req === 1'b1);

      rst = (e < 4);
      init_over_tx = 1'b1;
      pixel_empty = 1'b0;
      underflow_clr = 1'b0;
      if ((e >= 300 && e < 1200) || (e >= 1420 && e < 2000)) begin
        pixel_empty = ($urandom_range(5) == 0);
        underflow_clr = ($urandom_range(11) == 0);
      end
      if (e >= 1200 && e < 1400 && !rst_done && run && t == 2 * HT + 5) begin
        rst = 1'b1;
        rst_done = 1'b1;
      end
      if (e >= 1400 && e < 1420)
        init_over_tx = 1'b0;
      if (e >= 2000) begin
        pt = run ? (t + 1) % FR : 0;
        if (f_win(pt) && $urandom_range(7) == 0) begin
          pixel_empty = 1'b1;
          underflow_clr = 1'b1;
        end else begin
          underflow_clr = ($urandom_range(15) == 0);
        end
      end

      if (rst || !init_over_tx) begin
        nrun = 0;
        nt = 0;
      end else begin
        nrun = 1;
        nt = run ? (t + 1) % FR : 0;
      end
      srun[e] = nrun;
      st[e] = nt;
      fl[e] = rst || !init_over_tx;
      shit[e] = nrun && f_win(nt) && !pixel_empty;
      sword[e] = shit[e] ? 24'(word_mdl) : 24'h0;
      if (shit[e]) word_mdl++;

      if (rst)
        uf = 0;
      else if (e > 0 && srun[e-1] && f_win(st[e-1]) && !shit[e-1])
        uf = 1;
      else if (underflow_clr)
        uf = 0;

      x.e = e;
      x.req = shit[e];
      x.uf = uf;
      x.de = 0;
      x.hs = !HSP;
      x.vs = !VSP;
      x.fs = 0;
      x.data = 24'h0;
      if (e >= 2 && !fl[e] && !fl[e-1] && srun[e-2]) begin
        s = st[e-2];
        x.de = f_active(s);
        x.hs = f_hs(s) ? HSP : !HSP;
        x.vs = f_vs(s) ? VSP : !VSP;
        x.fs = (s == 0);
        if (shit[e-2])
          x.data = sword[e-2];
        else if (f_active(s))
          x.data = BRD;
      end
      sbq.push_back(x);
      run = nrun;
      t = nt;
    end

    repeat (3) @(posedge pixclk_in);
    #2;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d required=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
